// File: rtl/lsu.sv
// RV32I load/store unit: one req/gnt/rvalid data-memory transaction per decoded access.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of truncating them.
module lsu #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ls_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i
);
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    funct3_q;
   logic [1:0]    off_q;
   logic          we_q, err_q;
   logic [31:0]   addr_q, wdata_q, rdata_q;
   logic [3:0]    be_q;
   logic [CW-1:0] cnt_q;

   logic          accept, legal, misaligned, reject, timeout_hit, capture;
   logic [3:0]    be_new;
   logic [31:0]   wdata_new;

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{off, 3'b000} +: 8];
      h = d[{off[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return d;
      endcase
   endfunction

   assign accept = ls_i & (mem_read_i ^ mem_write_i);
   assign legal  = mem_write_i ? (funct3_i inside {3'b000, 3'b001, 3'b010})
                               : (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif
   assign reject = ~legal | misaligned;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      be_new    = 4'b1111;
      wdata_new = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_new    = 4'b0001 << addr_i[1:0];
            wdata_new = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);
   assign capture     = ((state_q == REQ) && dmem_gnt_i && !we_q && dmem_rvalid_i) ||
                        ((state_q == WAIT) && dmem_rvalid_i);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = reject ? RESP : REQ;
         REQ:     if (dmem_gnt_i) state_d = (we_q || dmem_rvalid_i) ? RESP : WAIT;
         WAIT:    if (dmem_rvalid_i || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o     = (state_q != IDLE);
      done_o     = (state_q == RESP);
      err_o      = (state_q == RESP) & err_q;
      dmem_req_o = (state_q == REQ);
   end

   // Request fields drive the bus directly, so they reset too: every output must read 0 in reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         funct3_q <= '0;
         off_q    <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         cnt_q <= (state_q == WAIT) ? cnt_q + CW'(1) : '0;
         if ((state_q == IDLE) && accept) begin
            funct3_q <= funct3_i;
            off_q    <= addr_i[1:0];
            we_q     <= mem_write_i;
            be_q     <= be_new;
            wdata_q  <= wdata_new;
            addr_q   <= {addr_i[31:2], 2'b00};
            err_q    <= reject;
            if (reject) rdata_q <= '0;
         end else if (capture) begin
            rdata_q <= load_ext(funct3_q, off_q, dmem_rdata_i);
         end else if ((state_q == WAIT) && timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end
      end
   end

   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_be_o    = be_q;
   assign dmem_wdata_o = wdata_q;
   assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses against a rule-level model.
module tb_lsu;
   localparam int unsigned TB_TIMEOUT = 4;

   logic        clk_i, rst_ni;
   logic        ls_i, mem_read_i, mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic        busy_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   int tests = 0;
   int fails = 0;

   lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ls_i(ls_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: access rules in plain arithmetic ----------------
   function automatic logic exp_bad(input logic wr, input logic [2:0] f3, input logic [31:0] a);
      logic lgl, mis;
      lgl = wr ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = ((f3 % 4 == 1) && (a % 2 != 0)) || ((f3 % 4 == 2) && (a % 4 != 0));
`endif
      return !lgl || mis;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      case (f3 % 4)
         0:       return 4'(1 << (a % 4));
         1:       return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
      case (f3 % 4)
         0:       return (w & 32'hFF) * 32'h01010101;
         1:       return (w & 32'hFFFF) * 32'h00010001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (8 * (a % 4))) & 32'hFF;
      h = ((a % 4) >= 2) ? (d >> 16) : (d & 32'hFFFF);
      case (f3)
         0:       return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
         1:       return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
         4:       return b;
         5:       return h;
         default: return d;
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] w);
      ls_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
      funct3_i = f3; addr_i = a; wdata_i = w;
      tick();
      ls_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      funct3_i = ~f3; addr_i = ~a; wdata_i = ~w;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_ni = 1'b0;
      ls_i = 0; mem_read_i = 0; mem_write_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
      dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
      #2;
      tests++;
      if ({busy_o, done_o, err_o, rdata_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b rdata=%h req=%b addr=%h be=%b, required all 0",
                  busy_o, done_o, err_o, rdata_o, dmem_req_o, dmem_addr_o, dmem_be_o);
      end
      tick(); tick();
      rst_ni = 1'b1;
      tick();
      tests++;
      if ({busy_o, done_o, dmem_req_o} !== 3'b000) begin
         fails++;
         $display("FAIL reset_release_idle: got busy/done/req=%b required 000", {busy_o, done_o, dmem_req_o});
      end
   endtask

   task automatic test_store_byte();
      issue(1'b0, 1'b1, 3'b000, 32'h103, 32'hAABBCCDD);
      tests++;
      if ({busy_o, done_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !==
          {1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 4'b1000, 32'hDDDDDDDD}) begin
         fails++;
         $display("FAIL sb_request: got req=%b we=%b addr=%h be=%b wdata=%h, required 1 1 00000100 1000 dddddddd",
                  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
      end
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      tests++;
      if ({done_o, err_o, dmem_req_o} !== 3'b100) begin
         fails++;
         $display("FAIL sb_done_t2: got done/err/req=%b required 100", {done_o, err_o, dmem_req_o});
      end
      tick();
      tests++;
      if ({busy_o, done_o} !== 2'b00) begin
         fails++;
         $display("FAIL sb_back_idle: got busy/done=%b required 00", {busy_o, done_o});
      end
   endtask

   task automatic test_load_byte();
      logic [31:0] expv [2];
      logic [2:0]  f3v  [2];
      f3v[0] = 3'b000; expv[0] = 32'hFFFFFF80;
      f3v[1] = 3'b100; expv[1] = 32'h00000080;
      for (int k = 0; k < 2; k++) begin
         issue(1'b1, 1'b0, f3v[k], 32'h102, 32'h0);
         tests++;
         if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o} !== {1'b1, 1'b0, 32'h100, 4'b0100}) begin
            fails++;
            $display("FAIL lb_request[%0d]: got req=%b we=%b addr=%h be=%b required 1 0 00000100 0100",
                     k, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o);
         end
         dmem_gnt_i = 1'b1;
         tick();
         dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h00800000;
         tests++;
         if ({busy_o, done_o, dmem_req_o} !== 3'b100) begin
            fails++;
            $display("FAIL lb_wait[%0d]: got busy/done/req=%b required 100", k, {busy_o, done_o, dmem_req_o});
         end
         tick();
         dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
         tests++;
         if ({done_o, err_o, rdata_o} !== {1'b1, 1'b0, expv[k]}) begin
            fails++;
            $display("FAIL lb_result_t3[%0d]: got done=%b err=%b rdata=%h required 1 0 %h",
                     k, done_o, err_o, rdata_o, expv[k]);
         end
         tick();
      end
   endtask

   task automatic test_load_half_stall();
      issue(1'b1, 1'b0, 3'b001, 32'h202, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, done_o} !== {1'b1, 1'b0, 32'h200, 4'b1100, 1'b0}) begin
            fails++;
            $display("FAIL lh_hold[%0d]: got req=%b addr=%h be=%b done=%b required 1 00000200 1100 0",
                     i, dmem_req_o, dmem_addr_o, dmem_be_o, done_o);
         end
         if (i < 3) begin
            dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
            tick();
         end
      end
      dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
      tick();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80011234;
      tick();
      dmem_rvalid_i = 1'b0;
      tests++;
      if ({done_o, err_o, rdata_o} !== {1'b1, 1'b0, 32'hFFFF8001}) begin
         fails++;
         $display("FAIL lh_result: got done=%b err=%b rdata=%h required 1 0 ffff8001", done_o, err_o, rdata_o);
      end
      tick();
   endtask

   task automatic test_ignore();
      logic [2:0] combo [3];
      combo[0] = 3'b111; combo[1] = 3'b100; combo[2] = 3'b010;
      for (int k = 0; k < 3; k++) begin
         {ls_i, mem_read_i, mem_write_i} = combo[k];
         funct3_i = 3'b010; addr_i = 32'h400;
         tick();
         tests++;
         if ({busy_o, done_o, dmem_req_o} !== 3'b000) begin
            fails++;
            $display("FAIL ignore[%0d]: got busy/done/req=%b required 000", k, {busy_o, done_o, dmem_req_o});
         end
      end
      {ls_i, mem_read_i, mem_write_i} = 3'b000;
   endtask

   task automatic test_illegal();
      logic       wrv [3];
      logic [2:0] f3v [3];
      wrv[0] = 1'b0; f3v[0] = 3'b011;
      wrv[1] = 1'b0; f3v[1] = 3'b110;
      wrv[2] = 1'b1; f3v[2] = 3'b100;
      for (int k = 0; k < 3; k++) begin
         issue(!wrv[k], wrv[k], f3v[k], 32'h500, 32'h12345678);
         tests++;
         if ({done_o, err_o, rdata_o, dmem_req_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL illegal[%0d]: got done=%b err=%b rdata=%h req=%b required 1 1 00000000 0",
                     k, done_o, err_o, rdata_o, dmem_req_o);
         end
         tick();
      end
   endtask

   task automatic test_misalign();
      issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      tests++;
      if ({done_o, err_o, rdata_o, dmem_req_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
         fails++;
         $display("FAIL misalign_trap: got done=%b err=%b rdata=%h req=%b required 1 1 00000000 0",
                  done_o, err_o, rdata_o, dmem_req_o);
      end
      tick();
`else
      tests++;
      if ({dmem_req_o, dmem_addr_o, dmem_be_o} !== {1'b1, 32'h100, 4'b1111}) begin
         fails++;
         $display("FAIL misalign_truncate: got req=%b addr=%h be=%b required 1 00000100 1111",
                  dmem_req_o, dmem_addr_o, dmem_be_o);
      end
      dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
      tick();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      tests++;
      if ({done_o, err_o, rdata_o} !== {1'b1, 1'b0, 32'h12345678}) begin
         fails++;
         $display("FAIL misalign_result: got done=%b err=%b rdata=%h required 1 0 12345678", done_o, err_o, rdata_o);
      end
      tick();
`endif
   endtask

   task automatic test_random(input int n);
      for (int k = 0; k < n; k++) begin
         logic        wr, bad, same;
         logic [2:0]  f3;
         logic [31:0] a, w, d;
         int          g, wl;
         wr = 1'($urandom % 2); f3 = 3'($urandom % 8);
         a = $urandom; w = $urandom; d = $urandom;
         bad = exp_bad(wr, f3, a);
         issue(!wr, wr, f3, a, w);
         if (bad) begin
            tests++;
            if ({done_o, err_o, rdata_o, dmem_req_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
               fails++;
               $display("FAIL rnd_reject[%0d]: f3=%0d wr=%b addr=%h got done=%b err=%b rdata=%h req=%b required 1 1 0 0",
                        k, f3, wr, a, done_o, err_o, rdata_o, dmem_req_o);
            end
         end else begin
            g = $urandom % 3;
            for (int i = 0; i <= g; i++) begin
               tests++;
               if ({busy_o, done_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !==
                   {1'b1, 1'b0, 1'b1, wr, a & 32'hFFFFFFFC, exp_be(f3, a), wr ? exp_wdata(f3, w) : dmem_wdata_o}) begin
                  fails++;
                  $display("FAIL rnd_request[%0d]: f3=%0d addr=%h got req=%b we=%b addr=%h be=%b wdata=%h required 1 %b %h %b %h",
                           k, f3, a, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                           wr, a & 32'hFFFFFFFC, exp_be(f3, a), exp_wdata(f3, w));
               end
               if (i < g) begin
                  dmem_rvalid_i = 1'($urandom % 2); dmem_rdata_i = $urandom;
                  tick();
               end
            end
            same = !wr && ($urandom % 3 == 0);
            dmem_gnt_i = 1'b1; dmem_rvalid_i = same; dmem_rdata_i = d;
            tick();
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
            if (!wr && !same) begin
               wl = $urandom % 3;
               for (int i = 0; i < wl; i++) begin
                  tests++;
                  if ({busy_o, done_o, dmem_req_o} !== 3'b100) begin
                     fails++;
                     $display("FAIL rnd_wait[%0d]: got busy/done/req=%b required 100", k, {busy_o, done_o, dmem_req_o});
                  end
                  tick();
               end
               dmem_rvalid_i = 1'b1; dmem_rdata_i = d;
               tick();
               dmem_rvalid_i = 1'b0;
            end
            tests++;
            if ({done_o, err_o} !== 2'b10 || (!wr && rdata_o !== exp_load(f3, a, d))) begin
               fails++;
               $display("FAIL rnd_result[%0d]: f3=%0d wr=%b addr=%h mem=%h got done=%b err=%b rdata=%h required 1 0 %h",
                        k, f3, wr, a, d, done_o, err_o, rdata_o, exp_load(f3, a, d));
            end
         end
         tick();
         tests++;
         if ({busy_o, done_o, err_o} !== 3'b000) begin
            fails++;
            $display("FAIL rnd_idle[%0d]: got busy/done/err=%b required 000", k, {busy_o, done_o, err_o});
         end
      end
   endtask

   task automatic test_timeout();
      issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
         tests++;
         if ({busy_o, done_o, dmem_req_o} !== 3'b100) begin
            fails++;
            $display("FAIL timeout_wait[%0d]: got busy/done/req=%b required 100", i, {busy_o, done_o, dmem_req_o});
         end
         tick();
      end
      tests++;
      if ({done_o, err_o, rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
         fails++;
         $display("FAIL timeout_err: got done=%b err=%b rdata=%h required 1 1 00000000", done_o, err_o, rdata_o);
      end
      tick();
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55555555;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests++;
         if ({busy_o, done_o, err_o} !== 3'b000) begin
            fails++;
            $display("FAIL stray_rvalid_idle[%0d]: got busy/done/err=%b required 000", i, {busy_o, done_o, err_o});
         end
      end
      dmem_rvalid_i = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
      dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
      tick();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      tick();
      issue(1'b1, 1'b0, 3'b010, 32'h604, 32'h0);
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      tests++;
      if ({busy_o, done_o, err_o, rdata_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== '0) begin
         fails++;
         $display("FAIL reset_in_wait: got busy=%b done=%b rdata=%h addr=%h be=%b, required all 0",
                  busy_o, done_o, rdata_o, dmem_addr_o, dmem_be_o);
      end
      #1;
      rst_ni = 1'b1;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h11111111;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests++;
         if ({busy_o, done_o, rdata_o} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL late_rvalid[%0d]: got busy=%b done=%b rdata=%h required 0 0 00000000",
                     i, busy_o, done_o, rdata_o);
         end
         dmem_rvalid_i = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_byte();
      test_load_half_stall();
      test_ignore();
      test_illegal();
      test_misalign();
      test_random(80);
      test_timeout();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit directly downstream of the RV32I instruction decoder. It consumes the decoder's ls_o, mem_read_o, mem_write_o and funct3_o, plus the ALU effective address and rs2 data. It runs one data-memory transaction over a req/gnt/rvalid bus, stalling the core while busy. It returns aligned, sign- or zero-extended load data to the register writeback path.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT for dmem_rvalid_i before an error completion; 0 disables the timeout

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
ls_i  in  1  access request from decoder (ls_o)
mem_read_i  in  1  load (decoder mem_read_o)
mem_write_i  in  1  store (decoder mem_write_o)
funct3_i  in  3  access size/sign (decoder funct3_o)
addr_i  in  32  effective address from ALU
wdata_i  in  32  store data (rs2)
busy_o  out  1  stall to core; high while not IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o; access failed
rdata_o  out  32  extended load data; valid with done_o
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word address, bits [1:0] = 0
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-positioned store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  32  read data

Behaviour:
- Reset (async, rst_ni=0): state IDLE; all outputs 0; timeout counter 0. Reset during REQ or WAIT abandons the access. A late rvalid after reset is ignored.
- FSM states are IDLE, REQ, WAIT, RESP.
- IDLE: accept when ls_i=1 and exactly one of mem_read_i/mem_write_i is 1. On accept, latch funct3, addr[1:0], we, be and positioned wdata, then go to REQ. Any other ls_i combination is ignored.
- REQ: dmem_req_o=1; addr/we/be/wdata are held stable until gnt.
  - Store with gnt goes to RESP.
  - Load with gnt goes to WAIT.
  - Load with gnt and rvalid in the same cycle captures data and goes to RESP.
- WAIT: on rvalid, capture dmem_rdata_i and go to RESP.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT (TIMEOUT>0), go to RESP with err=1 and data 0.
- RESP: done_o=1 for one cycle with err_o and rdata_o; then IDLE. Outside RESP, done_o=0, err_o=0 and rdata_o holds its last value.
- rvalid in IDLE/REQ (without gnt)/RESP is ignored.
- busy_o = (state != IDLE). It is registered, so it rises the cycle after accept.
- Latency, load with gnt in the first REQ cycle and rvalid one cycle later:
  - accept at T, req at T+1, rvalid at T+2, done_o at T+3.
- Latency, store with gnt in the first REQ cycle: done_o at T+2.
- Byte enables by funct3[1:0], o = addr[1:0]:
  - 00 (byte): be = 0001<<o; wdata = wdata_i[7:0] replicated x4.
  - 01 (half): be = 0011<<(2*addr[1]); wdata = wdata_i[15:0] replicated x2.
  - 10 (word): be = 1111; wdata = wdata_i.
- Load extraction:
  - LB 000 sign-extends the byte at o.
  - LH 001 sign-extends the half at addr[1].
  - LW 010 passes the word through.
  - LBU 100 and LHU 101 zero-extend.
  - Any other load funct3 returns err=1 and data 0 without a bus access.
  - Store funct3 other than 000/001/010 returns err=1 without a bus access.
- An illegal access goes IDLE→RESP directly.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access (half with addr[0]=1, word with addr[1:0]≠0) is not issued. dmem_req_o never asserts; the block goes IDLE→RESP with err_o=1 and rdata_o=0.
- Undefined: misalignment is not detected. Low address bits are truncated: half uses addr[1], word is fully aligned, and the access proceeds normally.

Test Plan:
- SB addr=0x103, wdata=0xAABBCCDD, gnt immediate → dmem_addr=0x100, be=1000, wdata=0xDDDDDDDD, done_o at T+2, err_o=0.
- LB addr=0x102, rdata=0x00800000, gnt at T+1, rvalid at T+2 → rdata_o=0xFFFFFF80 with done_o at T+3; LBU at the same address → 0x00000080.
- LH addr=0x202, gnt held low 3 cycles → dmem_req_o and be=1100 stable until gnt; rdata=0x8001_1234 gives rdata_o=0xFFFF8001.
- LW with TIMEOUT=4, rvalid never asserted → done_o with err_o=1, rdata_o=0 after 4 WAIT cycles; a later stray rvalid in IDLE is ignored.
- rst_ni pulsed low in WAIT → all outputs 0 immediately; a following rvalid produces no done_o.
- LW addr=0x101: with LSU_MISALIGN_TRAP_EN → no dmem_req_o, done_o with err_o=1 at T+1; without it → dmem_addr=0x100, be=1111, normal completion.
